// File: rtl/sme_pkg.sv
// Shared constants, FSM state encoding and case-folding helper for the
// multi-segment string-matching engine.
package sme_pkg;

   localparam logic [7:0] SC_BEGIN = 8'h5E;
   localparam logic [7:0] SC_END   = 8'h24;
   localparam logic [7:0] SC_ANY   = 8'h2E;
   localparam logic [7:0] SC_STAR  = 8'h2A;
   localparam logic [7:0] SC_SPACE = 8'h20;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD_S,
      ST_LOAD_P,
      ST_SEG_INIT,
      ST_CMP,
      ST_DONE
   } state_t;

   function automatic logic [7:0] fold_case(input logic [7:0] c);
      logic [7:0] r;
      r = c;
      if (c >= 8'h41 && c <= 8'h5A) r = c | 8'h20;
      return r;
   endfunction

endpackage

// File: rtl/sme_char_eq.sv
// Single pattern-char versus string-position comparator; at_end means the
// string position is one past the last stored char, so s_char is stale.
module sme_char_eq
   import sme_pkg::*;
(
   input  logic [7:0] s_char,
   input  logic [7:0] p_char,
   input  logic       at_start,
   input  logic       at_end,
   input  logic       nocase,
   output logic       eq
);

   always_comb begin
      eq = 1'b0;
      case (p_char)
         SC_ANY:   eq = !at_end;
         SC_BEGIN: eq = at_start || (!at_end && s_char == SC_SPACE);
         SC_END:   eq = at_end || s_char == SC_SPACE;
         default:  eq = !at_end && (nocase ? (fold_case(s_char) == fold_case(p_char))
                                           : (s_char == p_char));
      endcase
   end

endmodule

// File: rtl/sme_multiseg.sv
// String-matching engine: stores a string and a pattern with '*', '^', '$', '.',
// then matches '*'-separated segments greedily, one char comparison per cycle.
//
// state    | meaning
// IDLE     | waiting for string or pattern chars
// LOAD_S   | storing string chars
// LOAD_P   | storing pattern chars
// SEG_INIT | locate bounds of next segment, or finish with a match
// CMP      | compare one pattern char against one string char
// DONE     | result strobe (valid) for one cycle
module sme_multiseg
   import sme_pkg::*;
#(
   parameter  int STR_MAX = 32,
   parameter  int PAT_MAX = 16,
   localparam int IW      = $clog2(STR_MAX)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [7:0]    chardata,
   input  logic          isstring,
   input  logic          ispattern,
   input  logic          nocase,
   output logic          valid,
   output logic          match,
   output logic [IW-1:0] match_index,
   output logic          busy
);

   localparam int SW  = $clog2(STR_MAX + 1);
   localparam int PW  = $clog2(PAT_MAX + 2);
   localparam int PIW = $clog2(PAT_MAX);

   state_t        state, state_nx;
   logic [7:0]    str_mem [STR_MAX];
   logic [7:0]    pat_mem [PAT_MAX];
   logic [SW-1:0] slen, cand, spos, base;
   logic [PW-1:0] plen, seg_lo, seg_hi, k, star_hi, pp;
   logic [IW-1:0] idx;
   logic          nocase_r, match_r;

   logic          str_first, str_we, pat_first, pat_we;
   logic [7:0]    s_char, p_char;
   logic          at_start, at_end, eq, final_dollar, hit, adv, caret_skip, seg_end;

   assign pp       = seg_lo + k;
   assign p_char   = pat_mem[pp[PIW-1:0]];
   assign s_char   = str_mem[spos[IW-1:0]];
   assign at_start = (spos == '0);
   assign at_end   = (spos >= slen);

   sme_char_eq u_char_eq (
      .s_char   (s_char),
      .p_char   (p_char),
      .at_start (at_start),
      .at_end   (at_end),
      .nocase   (nocase_r),
      .eq       (eq)
   );

   // A '$' closing the whole pattern only accepts the true string end.
   assign final_dollar = (pp == plen - PW'(1)) && (p_char == SC_END);
   assign hit          = eq && !(final_dollar && !at_end);
   assign adv          = !((p_char == SC_BEGIN && at_start) || (p_char == SC_END && at_end));
   assign caret_skip   = (p_char == SC_BEGIN) && adv;
   assign seg_end      = (pp + PW'(1) == seg_hi);

   always_comb begin
      star_hi = plen;
      for (int i = PAT_MAX - 1; i >= 0; i--)
         if (PW'(i) >= seg_lo && PW'(i) < plen && pat_mem[i] == SC_STAR) star_hi = PW'(i);
   end

   always_comb begin
      state_nx  = state;
      str_first = 1'b0;
      str_we    = 1'b0;
      pat_first = 1'b0;
      pat_we    = 1'b0;
      case (state)
         ST_IDLE, ST_DONE: begin
            str_first = isstring;
            pat_first = !isstring && ispattern;
            if (isstring)       state_nx = ST_LOAD_S;
            else if (ispattern) state_nx = ST_LOAD_P;
            else                state_nx = ST_IDLE;
         end
         ST_LOAD_S: begin
            str_we    = isstring && (slen < SW'(STR_MAX));
            pat_first = !isstring && ispattern;
            if (pat_first) state_nx = ST_LOAD_P;
         end
         ST_LOAD_P: begin
            pat_we = ispattern && (plen < PW'(PAT_MAX));
            if (!ispattern) state_nx = ST_SEG_INIT;
         end
         ST_SEG_INIT: begin
            if (seg_lo > plen)           state_nx = ST_DONE;
            else if (star_hi != seg_lo)  state_nx = ST_CMP;
         end
         ST_CMP: begin
            if (hit && seg_end)          state_nx = ST_SEG_INIT;
            else if (!hit && cand >= slen) state_nx = ST_DONE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (str_first)   str_mem[0] <= chardata;
      else if (str_we) str_mem[slen[IW-1:0]] <= chardata;
      if (pat_first)   pat_mem[0] <= chardata;
      else if (pat_we) pat_mem[plen[PIW-1:0]] <= chardata;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= ST_IDLE;
         slen     <= '0;
         plen     <= '0;
         seg_lo   <= '0;
         seg_hi   <= '0;
         k        <= '0;
         cand     <= '0;
         spos     <= '0;
         base     <= '0;
         idx      <= '0;
         nocase_r <= 1'b0;
         match_r  <= 1'b0;
      end else begin
         state <= state_nx;
         if (str_first)   slen <= SW'(1);
         else if (str_we) slen <= slen + SW'(1);
         if (pat_first) begin
            plen     <= PW'(1);
            nocase_r <= nocase;
         end else if (pat_we) begin
            plen <= plen + PW'(1);
         end
         case (state)
            ST_LOAD_P: if (!ispattern) begin
               seg_lo  <= '0;
               base    <= '0;
               idx     <= '0;
               match_r <= 1'b0;
            end
            ST_SEG_INIT: begin
               if (seg_lo > plen) begin
                  match_r <= 1'b1;
               end else if (star_hi == seg_lo) begin
                  seg_lo <= star_hi + PW'(1);
               end else begin
                  seg_hi <= star_hi;
                  cand   <= base;
                  spos   <= base;
                  k      <= '0;
               end
            end
            ST_CMP: begin
               if (hit) begin
                  if (seg_lo == '0 && k == '0) idx <= IW'(cand + SW'(caret_skip));
                  if (seg_end) begin
                     base   <= spos + SW'(adv);
                     seg_lo <= seg_hi + PW'(1);
                  end else begin
                     k    <= k + PW'(1);
                     spos <= spos + SW'(adv);
                  end
               end else begin
                  cand <= cand + SW'(1);
                  spos <= cand + SW'(1);
                  k    <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   assign valid       = (state == ST_DONE);
   assign match       = valid && match_r;
   assign match_index = (valid && match_r) ? idx : '0;
   assign busy        = (state == ST_SEG_INIT) || (state == ST_CMP) || (state == ST_DONE) ||
                        (state == ST_LOAD_P && !ispattern);

endmodule

// File: tb/tb_sme_multiseg.sv
// Directed bench for sme_multiseg with hand-computed match results.
module tb_sme_multiseg;

   localparam int STR_MAX = 32;
   localparam int PAT_MAX = 16;
   localparam int IW      = $clog2(STR_MAX);
   localparam int BUDGET  = PAT_MAX * (STR_MAX + 2) + 4;

   logic          clk = 1'b0;
   logic          reset;
   logic [7:0]    chardata;
   logic          isstring, ispattern, nocase;
   logic          valid, match, busy;
   logic [IW-1:0] match_index;

   int n_chk  = 0;
   int n_pass = 0;

   sme_multiseg #(.STR_MAX(STR_MAX), .PAT_MAX(PAT_MAX)) dut (
      .clk         (clk),
      .reset       (reset),
      .chardata    (chardata),
      .isstring    (isstring),
      .ispattern   (ispattern),
      .nocase      (nocase),
      .valid       (valid),
      .match       (match),
      .match_index (match_index),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic drive(input logic [7:0] c, input logic s, input logic p, input logic nc);
      @(posedge clk);
      #1;
      chardata  = c;
      isstring  = s;
      ispattern = p;
      nocase    = nc;
   endtask

   task automatic load(input string s, input string p, input logic nc);
      for (int i = 0; i < s.len(); i++) drive(s[i], 1'b1, 1'b0, nc);
      for (int i = 0; i < p.len(); i++) drive(p[i], 1'b0, 1'b1, nc);
      drive(8'h00, 1'b0, 1'b0, nc);
   endtask

   task automatic run(input string tag, input string s, input string p, input logic nc,
                      input int exp_m, input int exp_i);
      int waited;
      load(s, p, nc);
      @(negedge clk);
      check({tag, "_busy_start"}, int'(busy), 1);
      waited = 0;
      while (!valid && waited < BUDGET) begin
         @(negedge clk);
         waited++;
      end
      check({tag, "_valid"}, int'(valid), 1);
      check({tag, "_match"}, int'(match), exp_m);
      check({tag, "_index"}, int'(match_index), exp_i);
      @(negedge clk);
      check({tag, "_valid_1cyc"}, int'(valid), 0);
      check({tag, "_busy_after"}, int'(busy), 0);
   endtask

   initial begin
      string s40;
      string p_bq;
      int    seen;
      reset = 1'b1;
      chardata = 8'h00;
      isstring = 1'b0;
      ispattern = 1'b0;
      nocase = 1'b0;
      p_bq = "x";
      p_bq[0] = 8'h60;
      repeat (2) @(negedge clk);
      check("rst_valid", int'(valid), 0);
      check("rst_match", int'(match), 0);
      check("rst_index", int'(match_index), 0);
      check("rst_busy",  int'(busy), 0);
      @(posedge clk);
      #1 reset = 1'b0;

      run("t1_wor",   "hello world", "wor",     1'b0, 1, 6);
      run("t2_anch",  "hello world", "^w.r*d$", 1'b0, 1, 6);
      run("t3_bcac",  "abcabcabc",   "b*c*a*c", 1'b0, 1, 1);
      run("t3_cbx",   "",            "c*b*x",   1'b0, 0, 0);
      run("t4_nc1",   "Hello",       "hELLO",   1'b1, 1, 0);
      run("t4_nc0",   "",            "hELLO",   1'b0, 0, 0);
      run("nc_spec",  "@",           p_bq,      1'b1, 0, 0);
      run("empty_p",  "xyz",         "**",      1'b0, 1, 0);

      s40 = "";
      for (int i = 0; i < 40; i++) begin
         if (i < 32) s40 = {s40, "a"};
         else        s40 = {s40, "z"};
      end
      run("t5_stdol", s40, "*$", 1'b0, 1, 0);
      run("t5_drop",  "",  "z",  1'b0, 0, 0);
      run("t5_last",  "",  "a$", 1'b0, 1, 31);

      load("abababababababab", "abx", 1'b0);
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      check("t6_rst_valid", int'(valid), 0);
      check("t6_rst_busy",  int'(busy), 0);
      check("t6_rst_index", int'(match_index), 0);
      @(posedge clk);
      #1 reset = 1'b0;
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (valid) seen++;
      end
      check("t6_no_valid", seen, 0);
      run("t6_empty_s", "", "a", 1'b0, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
